// File: rtl/antisat_pkg.sv
// Shared types and helpers for the Anti-SAT lock family.
package antisat_pkg;

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        LOAD   = 2'd1,
        ARMED  = 2'd2
    } antisat_state_t;

    // Widest compare vector antisat_g can reduce; locks must keep N at or below this.
    localparam int unsigned ANTISAT_G_W = 64;

    function automatic int unsigned antisat_key_w(input int unsigned n);
        return 2 * n;
    endfunction

    // N-input AND over the low n bits of vec.
    function automatic logic antisat_g(input logic [ANTISAT_G_W-1:0] vec, input int unsigned n);
        logic r;
        r = 1'b1;
        for (int unsigned i = 0; i < ANTISAT_G_W; i++) begin
            if (i < n) r &= vec[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/antisat_core.sv
// Combinational Anti-SAT flip: g(x^k1) & ~g(x^k2), g = N-input AND.
module antisat_core
    import antisat_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] k1,
    input  logic [N-1:0] k2,
    output logic         flip_raw
);

    assign flip_raw = antisat_g(ANTISAT_G_W'(x ^ k1), N) & ~antisat_g(ANTISAT_G_W'(x ^ k2), N);

endmodule

// File: rtl/antisat_seq_lock.sv
// Sequential Anti-SAT lock: serial key loader FSM driving a flip into the masked outputs.
// Define ANTISAT_OUT_REG_EN to register flip and data_out (one cycle of latency).
module antisat_seq_lock
    import antisat_pkg::*;
#(
    parameter int unsigned     N        = 4,
    parameter int unsigned     NOUT     = 1,
    parameter logic [NOUT-1:0] OUT_MASK = {NOUT{1'b1}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    x,
    input  logic [NOUT-1:0] data_in,
    input  logic            key_start,
    input  logic            key_vld,
    input  logic            key_in,
    output logic [NOUT-1:0] data_out,
    output logic            flip,
    output logic            armed,
    output logic            busy
);

    localparam int unsigned KW = antisat_key_w(N);
    localparam int unsigned CW = $clog2(KW + 1);

    antisat_state_t  state, state_nxt;
    logic [KW-1:0]   shift_q, shift_nxt, shift_in;
    logic [KW-1:0]   key_q, key_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic            core_flip;
    logic            flip_c;
    logic [NOUT-1:0] data_out_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LOCKED;
            shift_q <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            key_q   <= key_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // First bit received drifts down to key[0] once all 2N bits are in.
    assign shift_in = {key_in, shift_q[KW-1:1]};

    // key_start overrides everything, including a coincident key bit.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_q;
        key_nxt   = key_q;
        cnt_nxt   = cnt_q;
        if (key_start) begin
            state_nxt = LOAD;
            shift_nxt = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                LOAD: begin
                    if (key_vld) begin
                        shift_nxt = shift_in;
                        if (cnt_q == CW'(KW - 1)) begin
                            key_nxt   = shift_in;
                            cnt_nxt   = '0;
                            state_nxt = ARMED;
                        end else begin
                            cnt_nxt = cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    antisat_core #(.N(N)) u_core (
        .x        (x),
        .k1       (key_q[N-1:0]),
        .k2       (key_q[KW-1:N]),
        .flip_raw (core_flip)
    );

    // Outside ARMED every masked output is held inverted.
    assign flip_c     = (state == ARMED) ? core_flip : 1'b1;
    assign data_out_c = data_in ^ (OUT_MASK & {NOUT{flip_c}});

`ifdef ANTISAT_OUT_REG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flip     <= 1'b0;
            data_out <= '0;
        end else begin
            flip     <= flip_c;
            data_out <= data_out_c;
        end
    end
`else
    assign flip     = flip_c;
    assign data_out = data_out_c;
`endif

    assign armed = (state == ARMED);
    assign busy  = (state == LOAD);

endmodule
